// File: rtl/instr_fetch_assembler.sv
// instr_fetch_assembler
// ---------------------------------------------------------------------------
// Purpose:
//   Buffers instruction bytes coming from the memory read port in a small
//   FIFO, assembles variable-length instructions (an opcode followed by 0..2
//   operand bytes) and presents each complete instruction to the decode unit
//   under a valid/ready handshake.
//
// Parameters:
//   WIDTH      bits per instruction byte (>= 2)
//   MAX_BYTES  maximum bytes per instruction (1..3)
//   DEPTH      byte FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          in   rising-edge clock for all state
//   reset_n      in   asynchronous active-low reset
//   flush        in   synchronous clear of FIFO and assembler (branch taken)
//   byte_in      in   instruction byte from memory
//   byte_valid   in   byte_in is valid
//   byte_ready   out  FIFO can accept a byte (not full)
//   instr_out    out  assembled instruction, opcode in the low byte,
//                     operand k in byte k, unused bytes zero
//   instr_len    out  number of bytes in instr_out (1..MAX_BYTES)
//   instr_valid  out  instr_out/instr_len hold a complete instruction
//   instr_ready  in   decoder accepts the instruction
//   retired_cnt  out  16-bit count of accepted instructions
//                     (only when IFA_PERF_CNT_EN is defined)
//
// Configuration:
//   IFA_PERF_CNT_EN  adds the retired_cnt port and its wrapping counter,
//                    cleared by reset_n only (flush leaves it alone).
// ---------------------------------------------------------------------------
module instr_fetch_assembler #(
  parameter int WIDTH     = 8,
  parameter int MAX_BYTES = 3,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           byte_in,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  output logic [MAX_BYTES*WIDTH-1:0] instr_out,
  output logic [1:0]                 instr_len,
  output logic                       instr_valid,
  input  logic                       instr_ready
`ifdef IFA_PERF_CNT_EN
  ,
  output logic [15:0]                retired_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [1:0] MAX_LEN = 2'(MAX_BYTES);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_OPER  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] fifo_mem_q [DEPTH];
  logic [WIDTH-1:0] fifo_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Assembler state
  state_t           state_q, state_d;
  logic [WIDTH-1:0] slot_q [MAX_BYTES];
  logic [WIDTH-1:0] slot_d [MAX_BYTES];
  logic [1:0]       len_q, len_d;
  logic [1:0]       idx_q, idx_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             handshake;
  logic [WIDTH-1:0] head_byte;
  logic [1:0]       opcode_len;

  // Length from the top two opcode bits, clamped to what this instance
  // is configured to hold.
  function automatic logic [1:0] decode_len(input logic [WIDTH-1:0] op);
    logic [1:0] raw;
    if (op[WIDTH-1]) begin
      raw = 2'd3;
    end else if (op[WIDTH-2]) begin
      raw = 2'd2;
    end else begin
      raw = 2'd1;
    end
    if (raw > MAX_LEN) begin
      raw = MAX_LEN;
    end
    return raw;
  endfunction

  assign fifo_empty  = (count_q == '0);
  assign byte_ready  = (count_q != FULL_CNT);
  assign head_byte   = fifo_mem_q[rd_ptr_q];
  assign opcode_len  = decode_len(head_byte);
  assign instr_valid = (state_q == ST_HOLD);
  assign instr_len   = len_q;

  // A flush swallows any byte offered in the same cycle, and a handshake
  // colliding with a flush does not retire the instruction.
  assign push      = byte_valid && byte_ready && !flush;
  assign handshake = instr_valid && instr_ready && !flush;

  always_comb begin
    instr_out = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      instr_out[k*WIDTH +: WIDTH] = slot_q[k];
    end
  end

  // Assembler next state: at most one pop per cycle, never in HOLD, so
  // the handshake cycle never consumes a byte.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      slot_d[k] = slot_q[k];
    end

    unique case (state_q)
      ST_FETCH: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          slot_d[0] = head_byte;
          for (int k = 1; k < MAX_BYTES; k++) begin
            slot_d[k] = '0;
          end
          len_d   = opcode_len;
          idx_d   = 2'd1;
          state_d = (opcode_len == 2'd1) ? ST_HOLD : ST_OPER;
        end
      end
      ST_OPER: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          for (int k = 0; k < MAX_BYTES; k++) begin
            if (2'(k) == idx_q) begin
              slot_d[k] = head_byte;
            end
          end
          if (idx_q == len_q - 2'd1) begin
            state_d = ST_HOLD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (flush) begin
      state_d = ST_FETCH;
      len_d   = '0;
      idx_d   = '0;
      pop     = 1'b0;
      for (int k = 0; k < MAX_BYTES; k++) begin
        slot_d[k] = '0;
      end
    end
  end

  // FIFO next state. Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      fifo_mem_d[k] = fifo_mem_q[k];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_mem_d[wr_ptr_q] = byte_in;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        fifo_mem_q[k] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        fifo_mem_q[k] <= fifo_mem_d[k];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      len_q   <= '0;
      idx_q   <= '0;
      for (int k = 0; k < MAX_BYTES; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      for (int k = 0; k < MAX_BYTES; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

`ifdef IFA_PERF_CNT_EN
  logic [15:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (handshake) begin
      retired_cnt_d = retired_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_cnt_q <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// tb_instr_fetch_assembler
// Directed testbench for instr_fetch_assembler with default parameters
// (8-bit bytes, up to 3 bytes per instruction, 4-entry FIFO). Inputs change
// 1 ns after each rising edge and outputs are sampled there as well.
module tb_instr_fetch_assembler;

  localparam int WIDTH     = 8;
  localparam int MAX_BYTES = 3;
  localparam int DEPTH     = 4;
  localparam int OUT_W     = WIDTH * MAX_BYTES;

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic [WIDTH-1:0] byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [OUT_W-1:0] instr_out;
  logic [1:0]       instr_len;
  logic             instr_valid;
  logic             instr_ready;
`ifdef IFA_PERF_CNT_EN
  logic [15:0]      retired_cnt;
`endif

  int n_checks;
  int n_errors;

  instr_fetch_assembler #(
    .WIDTH     (WIDTH),
    .MAX_BYTES (MAX_BYTES),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .instr_out   (instr_out),
    .instr_len   (instr_len),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef IFA_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    flush       = 1'b0;
    byte_in     = '0;
    byte_valid  = 1'b0;
    instr_ready = 1'b0;
    #3;
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid);
    end
    n_checks++;
    if (instr_out !== 24'h000000) begin
      n_errors++;
      $display("[TB] FAIL reset_out: got %h expected 000000", instr_out);
    end
    n_checks++;
    if (instr_len !== 2'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_len: got %0d expected 0", instr_len);
    end
    n_checks++;
    if (byte_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL reset_byte_ready: got %b expected 1", byte_ready);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_one_byte();
    instr_ready = 1'b1;
    byte_in     = 8'h05;
    byte_valid  = 1'b1;
    tick();
    byte_valid = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL one_byte_early: got %b expected 0", instr_valid);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_out !== 24'h000005 || instr_len !== 2'd1) begin
      n_errors++;
      $display("[TB] FAIL one_byte_instr: got v=%b out=%h len=%0d expected v=1 out=000005 len=1",
               instr_valid, instr_out, instr_len);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL one_byte_single_cycle: got %b expected 0", instr_valid);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_three_byte_gaps();
    instr_ready = 1'b0;
    byte_in     = 8'h80;
    byte_valid  = 1'b1;
    tick();
    byte_valid = 1'b0;
    tick();
    tick();
    byte_in    = 8'h34;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    tick();
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL three_byte_partial: got %b expected 0", instr_valid);
    end
    byte_in    = 8'h12;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL three_byte_before_last_pop: got %b expected 0", instr_valid);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_out !== 24'h123480 || instr_len !== 2'd3) begin
      n_errors++;
      $display("[TB] FAIL three_byte_instr: got v=%b out=%h len=%0d expected v=1 out=123480 len=3",
               instr_valid, instr_out, instr_len);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_out !== 24'h123480 || instr_len !== 2'd3) begin
        n_errors++;
        $display("[TB] FAIL three_byte_hold%0d: got v=%b out=%h len=%0d expected v=1 out=123480 len=3",
                 i, instr_valid, instr_out, instr_len);
      end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL three_byte_release: got %b expected 0", instr_valid);
    end
  endtask

  task automatic test_backpressure();
    int delivered;
    int cycles;
    bit accept;
    instr_ready = 1'b0;
    byte_in     = 8'h01;
    byte_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    n_checks++;
    if (byte_ready !== 1'b0 || instr_valid !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL backpressure_full: got ready=%b valid=%b expected ready=0 valid=1",
               byte_ready, instr_valid);
    end
    tick();
    n_checks++;
    if (byte_ready !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL backpressure_stall: got ready=%b expected 0", byte_ready);
    end
    instr_ready = 1'b1;
    delivered   = 0;
    cycles      = 0;
    while ((delivered < 6 || byte_valid) && cycles < 60) begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (instr_out !== 24'h000001 || instr_len !== 2'd1) begin
          n_errors++;
          $display("[TB] FAIL backpressure_instr%0d: got out=%h len=%0d expected out=000001 len=1",
                   delivered, instr_out, instr_len);
        end
        delivered++;
      end
      accept = byte_valid && byte_ready;
      tick();
      if (accept) byte_valid = 1'b0;
      cycles++;
    end
    n_checks++;
    if (delivered != 6) begin
      n_errors++;
      $display("[TB] FAIL backpressure_count: got %0d expected 6", delivered);
    end
    tick();
    tick();
    n_checks++;
    if (instr_valid !== 1'b0 || byte_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL backpressure_drained: got valid=%b ready=%b expected valid=0 ready=1",
               instr_valid, byte_ready);
    end
    byte_valid  = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic test_flush();
    instr_ready = 1'b1;
    byte_in     = 8'h40;
    byte_valid  = 1'b1;
    tick();
    byte_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || instr_out !== 24'h000000 || byte_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL flush_clear: got v=%b out=%h ready=%b expected v=0 out=000000 ready=1",
               instr_valid, instr_out, byte_ready);
    end
    byte_in    = 8'h02;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_out !== 24'h000002 || instr_len !== 2'd1) begin
      n_errors++;
      $display("[TB] FAIL flush_next_instr: got v=%b out=%h len=%0d expected v=1 out=000002 len=1",
               instr_valid, instr_out, instr_len);
    end
    tick();
    // A byte offered together with flush must be dropped.
    byte_in    = 8'h03;
    byte_valid = 1'b1;
    flush      = 1'b1;
    tick();
    byte_valid = 1'b0;
    flush      = 1'b0;
    tick();
    tick();
    n_checks++;
    if (instr_valid !== 1'b0 || instr_out !== 24'h000000) begin
      n_errors++;
      $display("[TB] FAIL flush_drops_push: got v=%b out=%h expected v=0 out=000000",
               instr_valid, instr_out);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] stream [4];
    logic [OUT_W-1:0] exp_out [3];
    logic [1:0]       exp_len [3];
    int sent;
    int got;
    int cycles;
    bit accept;
    stream[0] = 8'h01; stream[1] = 8'h45; stream[2] = 8'h67; stream[3] = 8'h05;
    exp_out[0] = 24'h000001; exp_len[0] = 2'd1;
    exp_out[1] = 24'h006745; exp_len[1] = 2'd2;
    exp_out[2] = 24'h000005; exp_len[2] = 2'd1;
    instr_ready = 1'b1;
    sent   = 0;
    got    = 0;
    cycles = 0;
    while ((got < 3 || sent < 4) && cycles < 40) begin
      byte_valid = (sent < 4);
      byte_in    = stream[sent % 4];
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (got >= 3 || instr_out !== exp_out[got % 3] || instr_len !== exp_len[got % 3]) begin
          n_errors++;
          $display("[TB] FAIL b2b_instr%0d: got out=%h len=%0d expected out=%h len=%0d",
                   got, instr_out, instr_len, exp_out[got % 3], exp_len[got % 3]);
        end
        got++;
      end
      accept = byte_valid && byte_ready;
      tick();
      if (accept) sent++;
      cycles++;
    end
    byte_valid = 1'b0;
    n_checks++;
    if (got != 3) begin
      n_errors++;
      $display("[TB] FAIL b2b_count: got %0d expected 3", got);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    instr_ready = 1'b0;
    byte_in     = 8'h80;
    byte_valid  = 1'b1;
    tick();
    byte_in = 8'h34;
    tick();
    byte_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || instr_out !== 24'h000000 || byte_ready !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL mid_reset: got v=%b out=%h ready=%b expected v=0 out=000000 ready=1",
               instr_valid, instr_out, byte_ready);
    end
    tick();
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    byte_in     = 8'h05;
    byte_valid  = 1'b1;
    tick();
    byte_valid = 1'b0;
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_out !== 24'h000005 || instr_len !== 2'd1) begin
      n_errors++;
      $display("[TB] FAIL mid_reset_restart: got v=%b out=%h len=%0d expected v=1 out=000005 len=1",
               instr_valid, instr_out, instr_len);
    end
    tick();
    instr_ready = 1'b0;
  endtask

`ifdef IFA_PERF_CNT_EN
  task automatic test_perf_cnt();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++;
    if (retired_cnt !== 16'd0) begin
      n_errors++;
      $display("[TB] FAIL perf_reset: got %0d expected 0", retired_cnt);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      byte_in    = 8'h07;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
      tick();
      tick();
    end
    n_checks++;
    if (retired_cnt !== 16'd3) begin
      n_errors++;
      $display("[TB] FAIL perf_three: got %0d expected 3", retired_cnt);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (retired_cnt !== 16'd3) begin
      n_errors++;
      $display("[TB] FAIL perf_flush: got %0d expected 3", retired_cnt);
    end
    instr_ready = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_one_byte();
    test_three_byte_gaps();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_mid_reset();
`ifdef IFA_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
